// File: rtl/aurora_link_supervisor.sv
// Aurora 64B/66B link bring-up and recovery supervisor.
// Sequences pma_init/reset_pb, waits for channel_up with backoff, tracks errors.
module aurora_link_supervisor #(
    parameter int LANES           = 2,
    parameter int RST_HOLD        = 256,
    parameter int UP_TIMEOUT      = 100000,
    parameter int SOFT_ERR_LIMIT  = 8,
    parameter int SOFT_ERR_WINDOW = 65536,
    parameter int MAX_RETRY       = 7,
    parameter int CNT_W           = 16
) (
    input  logic             init_clk,
    input  logic             system_rst_n,
    input  logic             enable,
    input  logic             clear_stats,
    input  logic             channel_up,
    input  logic [LANES-1:0] lane_up,
    input  logic             hard_err,
    input  logic             soft_err,
    input  logic             gt_pll_lock,
    output logic             pma_init,
    output logic             reset_pb,
    output logic             link_ok,
    output logic [2:0]       link_state,
    output logic             give_up,
    output logic [2:0]       retry_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] soft_err_cnt,
    output logic [CNT_W-1:0] hard_err_cnt
);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_PMA_RST = 3'd1,
        S_PB_RST  = 3'd2,
        S_WAIT_UP = 3'd3,
        S_UP      = 3'd4,
        S_FAILED  = 3'd5
    } state_t;

    localparam int WIN_W = (SOFT_ERR_WINDOW > 1) ? $clog2(SOFT_ERR_WINDOW) : 1;
    localparam int SW_W  = $clog2(SOFT_ERR_LIMIT + 1);
    localparam int IN_W  = LANES + 4;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SOFT_ERR_WINDOW - 1);
    localparam logic [SW_W-1:0]  SW_LIM   = SW_W'(SOFT_ERR_LIMIT);

    state_t state;
    state_t next_state;

    logic [IN_W-1:0]  meta;
    logic [IN_W-1:0]  sync;
    logic             cu_q;
    logic             hard_q;
    logic             soft_q;
    logic             cu_s;
    logic             hard_s;
    logic             soft_s;
    logic             lock_s;
    logic [LANES-1:0] lane_s;
    logic             cu_fall;
    logic             hard_rise;
    logic             soft_rise;
    logic             link_ready;

    logic [31:0]      timer;
    logic [31:0]      up_limit;
    logic [1:0]       bo_sh;
    logic             hold_done;
    logic             up_expired;
    logic             retry_over;
    logic             retry_inc;
    logic             drop;
    logic             up_entry;

    logic [WIN_W-1:0] win_cnt;
    logic             win_wrap;
    logic [SW_W-1:0]  soft_win;
    logic [SW_W-1:0]  soft_base;
    logic [SW_W-1:0]  soft_win_nxt;
    logic             soft_burst;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Two-flop synchronisers plus a third stage for edge detection
    always_ff @(posedge init_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            meta   <= '0;
            sync   <= '0;
            cu_q   <= 1'b0;
            hard_q <= 1'b0;
            soft_q <= 1'b0;
        end else begin
            meta   <= {gt_pll_lock, soft_err, hard_err, lane_up, channel_up};
            sync   <= meta;
            cu_q   <= cu_s;
            hard_q <= hard_s;
            soft_q <= soft_s;
        end
    end

    assign cu_s       = sync[0];
    assign lane_s     = sync[LANES:1];
    assign hard_s     = sync[LANES+1];
    assign soft_s     = sync[LANES+2];
    assign lock_s     = sync[LANES+3];

    assign cu_fall    = cu_q & ~cu_s;
    assign hard_rise  = hard_s & ~hard_q;
    assign soft_rise  = soft_s & ~soft_q;
    assign link_ready = cu_s & (&lane_s);

    assign bo_sh      = (retry_cnt > 3'd3) ? 2'd3 : retry_cnt[1:0];
    assign up_limit   = 32'(UP_TIMEOUT) << bo_sh;
    assign hold_done  = timer >= 32'(RST_HOLD - 1);
    assign up_expired = timer >= (up_limit - 32'd1);
    assign retry_over = ({29'd0, retry_cnt} + 32'd1) > 32'(MAX_RETRY);

    // An edge on the wrap cycle lands in the fresh window
    assign win_wrap     = (win_cnt == WIN_LAST);
    assign soft_base    = win_wrap ? '0 : soft_win;
    assign soft_win_nxt = (soft_rise && (soft_base < SW_LIM))
                        ? soft_base + SW_W'(1) : soft_base;
    assign soft_burst   = soft_rise && (soft_win_nxt >= SW_LIM);

    always_ff @(posedge init_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state <= S_HOLD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        retry_inc  = 1'b0;
        drop       = 1'b0;
        if (!enable) begin
            next_state = S_HOLD;
        end else begin
            unique case (state)
                S_HOLD: begin
                    next_state = S_PMA_RST;
                end
                S_PMA_RST: begin
                    if (hold_done) next_state = S_PB_RST;
                end
                S_PB_RST: begin
                    if (hold_done && lock_s) next_state = S_WAIT_UP;
                end
                S_WAIT_UP: begin
                    if (hard_rise || (!link_ready && up_expired)) begin
                        retry_inc  = 1'b1;
                        next_state = retry_over ? S_FAILED : S_PMA_RST;
                    end else if (link_ready) begin
                        next_state = S_UP;
                    end
                end
                S_UP: begin
                    if (cu_fall || hard_rise || soft_burst) begin
                        drop       = 1'b1;
                        next_state = S_PMA_RST;
                    end
                end
                S_FAILED: begin
                    next_state = S_FAILED;
                end
                default: begin
                    next_state = S_HOLD;
                end
            endcase
        end
    end

    assign up_entry = (next_state == S_UP) && (state != S_UP);

    // Phase timer restarts on every state change and saturates
    always_ff @(posedge init_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            timer <= '0;
        end else if (next_state != state) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + 32'd1;
        end
    end

    always_ff @(posedge init_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            win_cnt  <= '0;
            soft_win <= '0;
        end else if (up_entry) begin
            win_cnt  <= '0;
            soft_win <= '0;
        end else begin
            win_cnt  <= win_wrap ? '0 : win_cnt + WIN_W'(1);
            soft_win <= soft_win_nxt;
        end
    end

    always_ff @(posedge init_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            retry_cnt    <= '0;
            drop_cnt     <= '0;
            soft_err_cnt <= '0;
            hard_err_cnt <= '0;
        end else if (clear_stats) begin
            retry_cnt    <= '0;
            drop_cnt     <= '0;
            soft_err_cnt <= '0;
            hard_err_cnt <= '0;
        end else begin
            if (up_entry) begin
                retry_cnt <= '0;
            end else if (retry_inc && (retry_cnt != 3'd7)) begin
                retry_cnt <= retry_cnt + 3'd1;
            end
            if (drop) drop_cnt <= sat_inc(drop_cnt);
            if (soft_rise) soft_err_cnt <= sat_inc(soft_err_cnt);
            if (hard_rise && ((state == S_UP) || (state == S_WAIT_UP))) begin
                hard_err_cnt <= sat_inc(hard_err_cnt);
            end
        end
    end

    always_ff @(posedge init_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            pma_init <= 1'b1;
            reset_pb <= 1'b1;
            link_ok  <= 1'b0;
            give_up  <= 1'b0;
        end else begin
            pma_init <= (next_state == S_HOLD) || (next_state == S_PMA_RST) ||
                        (next_state == S_FAILED);
            reset_pb <= (next_state != S_WAIT_UP) && (next_state != S_UP);
            link_ok  <= (next_state == S_UP);
            give_up  <= (next_state == S_FAILED);
        end
    end

    assign link_state = state;

endmodule

// File: doc/aurora_link_supervisor.md
# aurora_link_supervisor

Parametrised link-bring-up and recovery controller for Aurora 64B/66B channels of 1–4 lanes, clocked on the free-running init clock. It drives the core's `pma_init` and `reset_pb` in the required order and waits for `channel_up` with a bounded, backed-off timeout. It supervises hard errors and soft-error bursts, retries bring-up a limited number of times, and exports link state plus saturating statistics counters. It sits between system reset logic and each Aurora channel instance, replacing the fixed reset-sync-only scheme.

## Interface
- `LANES`, 2, lane count (1–4); width of `lane_up`.
- `RST_HOLD`, 256, cycles `pma_init` is held; also the cycles `reset_pb` is held after `pma_init` releases.
- `UP_TIMEOUT`, 100000, base cycles allowed from `reset_pb` release to `channel_up`.
- `SOFT_ERR_LIMIT`, 8, soft-error edges within one window that force recovery.
- `SOFT_ERR_WINDOW`, 65536, window length in cycles.
- `MAX_RETRY`, 7, failed bring-ups tolerated before entering FAILED.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `init_clk` in 1: sole clock.
- `system_rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 0 holds the block in HOLD.
- `clear_stats` in 1: single-cycle pulse; zeroes all statistics counters and `retry_cnt`.
- `channel_up` in 1: from core (user_clk domain); synchronised internally.
- `lane_up` in LANES: from core; synchronised internally.
- `hard_err` in 1: from core; synchronised internally.
- `soft_err` in 1: from core; synchronised internally.
- `gt_pll_lock` in 1: from core; synchronised internally.
- `pma_init` out 1: to core.
- `reset_pb` out 1: to core.
- `link_ok` out 1: high only in UP.
- `link_state` out 3: HOLD=0, PMA_RST=1, PB_RST=2, WAIT_UP=3, UP=4, FAILED=5.
- `give_up` out 1: high in FAILED.
- `retry_cnt` out 3: consecutive failed attempts, saturating at 7.
- `drop_cnt` out CNT_W: UP exits, saturating.
- `soft_err_cnt` out CNT_W: total soft-error edges, saturating.
- `hard_err_cnt` out CNT_W: hard-error edges seen in UP or WAIT_UP, saturating.

## Operation
- Every core input passes through a 2-FF synchroniser. Error inputs are edge-detected after synchronisation: one count per synchronised rising edge.
- State machine:
  - **HOLD**: `pma_init`=1, `reset_pb`=1. Goes to PMA_RST when `enable`=1.
  - **PMA_RST**: `pma_init`=1, `reset_pb`=1. After RST_HOLD cycles, goes to PB_RST.
  - **PB_RST**: `pma_init`=0, `reset_pb`=1. Goes to WAIT_UP once RST_HOLD cycles have elapsed and synced `gt_pll_lock`=1. If lock is absent it waits indefinitely.
  - **WAIT_UP**: both resets 0.
    - Timeout T = UP_TIMEOUT << min(`retry_cnt`,3).
    - Goes to UP on synced `channel_up`=1 with all `lane_up` bits =1.
    - On timeout or hard-error edge: increment `retry_cnt`, then go to FAILED if `retry_cnt` (post-increment) > MAX_RETRY, otherwise to PMA_RST.
  - **UP**: `link_ok`=1, and `retry_cnt` clears on entry.
    - Exits to PMA_RST (and `drop_cnt`++) on any of: `channel_up` falling, a hard-error edge, or soft-error edges in the current window reaching SOFT_ERR_LIMIT.
  - **FAILED**: `pma_init`=1, `reset_pb`=1, `give_up`=1. The only exits are `enable`=0 (to HOLD) and reset.
- `enable`=0 in any state goes to HOLD the next cycle. HOLD does not clear `retry_cnt`.
- Soft-error window:
  - Free-running window counter, restarted on UP entry.
  - The window edge count resets at each window wrap.
  - A soft error on the wrap cycle counts in the new window.
- All counters saturate at all-ones and never wrap.
- If `clear_stats` coincides with an increment, the counter becomes 0.

## Timing
- Reset values of outputs:
  - `pma_init`=1, `reset_pb`=1.
  - `link_state`=HOLD.
  - `link_ok`=0, `give_up`=0.
  - All counters = 0.
- All outputs are registered and follow the state register with zero additional latency.
- Input-to-state latency is 3 cycles: 2 synchroniser cycles plus 1 state cycle.
- PMA_RST and PB_RST each last exactly RST_HOLD cycles when lock is already present.
- An asynchronous reset mid-sequence forces the reset values immediately. Bring-up restarts from HOLD.

## Test plan
- **Basic bring-up.** Parameters RST_HOLD=4, UP_TIMEOUT=50, lock=1. Drive `enable`=1, then `channel_up`/`lane_up`=1 at cycle 20. Required:
  - `pma_init` falls 4 cycles after PMA_RST entry.
  - `reset_pb` falls 4 cycles later.
  - `link_ok`=1 3 cycles after `channel_up`.
- **Timeout backoff.** Never raise `channel_up`. Required:
  - WAIT_UP lasts 50, 100, 200, 400, 400… cycles on successive attempts.
  - FAILED is entered after attempt 8 with MAX_RETRY=7; `give_up`=1.
- **Soft-error limit.** SOFT_ERR_LIMIT=3, SOFT_ERR_WINDOW=100, in UP. Required:
  - 3 pulses within 100 cycles: exit to PMA_RST, `drop_cnt`=1, `soft_err_cnt`=3.
  - 2 pulses per window: stays in UP.
- **Hard error in UP.** Pulse `hard_err`. Required: PMA_RST entered 3 cycles later, `hard_err_cnt`=1, `drop_cnt`=1.
- **Missing lock.** Hold `gt_pll_lock`=0. Required: stays in PB_RST indefinitely; raising lock enters WAIT_UP 3 cycles later.
- **Reset and saturation.** CNT_W=2, force 5 drops. Required:
  - `drop_cnt`=3 after the drops.
  - `clear_stats` coincident with a drop gives `drop_cnt`=0.
  - Asserting `system_rst_n`=0 during WAIT_UP gives `pma_init`=1 and HOLD with no clock edge.
